// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_ADDI = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_ANDI = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;

  // Bit positions inside the packed flag vector
  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_C   = 2;
  localparam int FLG_V   = 3;
  localparam int FLG_ERR = 4;
  localparam int NFLAGS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DWIDTH bits kept.
// done is high in the cycle whose closing edge performs the final step;
// product_next is the value the accumulator takes at that edge.
module alu_mul_iter #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              done,
  output logic [DWIDTH-1:0] product_next,
  output logic [DWIDTH-1:0] product
);

  localparam int SHW = $clog2(DWIDTH);

  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] partial;
  logic [SHW-1:0]    cnt;
  logic              busy;

  assign partial      = b_q[cnt] ? (a_q << cnt) : '0;
  assign product_next = acc + partial;
  assign product      = acc;
  assign done         = busy && (cnt == SHW'(DWIDTH - 1));

  // Latch operands on start, then accumulate one bit of b per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= product_next;
      cnt <= cnt + SHW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and an iterative multiplier.
// state   | meaning
// IDLE    | accepting ops; single-cycle results load the output register directly
// MUL     | multiplier stepping, input channel stalled
// HOLD    | product ready but output register still occupied
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_func,
  input  logic [DWIDTH-1:0] alu_a,
  input  logic [DWIDTH-1:0] alu_b,
  input  logic [DWIDTH-1:0] alu_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] alu_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_err
);

  localparam int SHW = $clog2(DWIDTH);

  state_t              state;
  logic [NFLAGS-1:0]   flags_q;
  logic [NFLAGS-1:0]   alu_flags;
  logic [NFLAGS-1:0]   mul_flags;
  logic [DWIDTH-1:0]   res;
  logic [DWIDTH-1:0]   add_opnd;
  logic [DWIDTH:0]     add_full;
  logic [DWIDTH:0]     sub_full;
  logic [SHW-1:0]      sh;
  logic [DWIDTH-1:0]   mul_next;
  logic [DWIDTH-1:0]   mul_product;
  logic [DWIDTH-1:0]   mul_src;
  logic                mul_done;
  logic                out_free;
  logic                accept;
  logic                mul_start;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == ST_IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alu_func == ALU_MUL);

  assign add_opnd = (alu_func == ALU_ADDI) ? alu_imm : alu_b;
  assign add_full = {1'b0, alu_a} + {1'b0, add_opnd};
  assign sub_full = {1'b0, alu_a} + {1'b0, ~alu_b} + (DWIDTH + 1)'(1);
  assign sh       = alu_b[SHW-1:0];

  alu_mul_iter #(.DWIDTH(DWIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .a            (alu_a),
    .b            (alu_b),
    .done         (mul_done),
    .product_next (mul_next),
    .product      (mul_product)
  );

  // Single-cycle datapath: result and flags for every non-multiply opcode
  always_comb begin
    res       = '0;
    alu_flags = '0;
    case (alu_func)
      ALU_ADD, ALU_ADDI: begin
        res              = add_full[DWIDTH-1:0];
        alu_flags[FLG_C] = add_full[DWIDTH];
        alu_flags[FLG_V] = (alu_a[DWIDTH-1] == add_opnd[DWIDTH-1]) &&
                           (res[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      ALU_SUB: begin
        res              = sub_full[DWIDTH-1:0];
        alu_flags[FLG_C] = sub_full[DWIDTH];
        alu_flags[FLG_V] = (alu_a[DWIDTH-1] != alu_b[DWIDTH-1]) &&
                           (res[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      ALU_AND:  res = alu_a & alu_b;
      ALU_ANDI: res = alu_a & alu_imm;
      ALU_OR:   res = alu_a | alu_b;
      ALU_XOR:  res = alu_a ^ alu_b;
      ALU_SLL:  res = alu_a << sh;
      ALU_SRL:  res = alu_a >> sh;
      ALU_SRA:  res = $signed(alu_a) >>> sh;
      ALU_SLT:  res = {{(DWIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: res = {{(DWIDTH-1){1'b0}}, (alu_a < alu_b)};
      ALU_MUL:  res = '0;
      default:  alu_flags[FLG_ERR] = 1'b1;
    endcase
    alu_flags[FLG_Z] = (res == '0);
    alu_flags[FLG_N] = res[DWIDTH-1];
  end

  // Product source: the finishing step in MUL, the settled accumulator in HOLD
  always_comb begin
    mul_src          = (state == ST_HOLD) ? mul_product : mul_next;
    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_src == '0);
    mul_flags[FLG_N] = mul_src[DWIDTH-1];
  end

  // Sequencing FSM and output register; a load overrides a same-edge consumption
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      flags_q   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (alu_func == ALU_MUL) begin
              state <= ST_MUL;
            end else begin
              alu_out   <= res;
              flags_q   <= alu_flags;
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            if (out_free) begin
              alu_out   <= mul_src;
              flags_q   <= mul_flags;
              out_valid <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_free) begin
            alu_out   <= mul_src;
            flags_q   <= mul_flags;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flag_z   = flags_q[FLG_Z];
  assign flag_n   = flags_q[FLG_N];
  assign flag_c   = flags_q[FLG_C];
  assign flag_v   = flags_q[FLG_V];
  assign flag_err = flags_q[FLG_ERR];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (DWIDTH=16): directed vectors, decoupled monitor.
// Expected flag vectors are written as {err, v, c, n, z}.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_func = 4'd0;
  logic [15:0] alu_a = '0;
  logic [15:0] alu_b = '0;
  logic [15:0] alu_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] alu_out;
  logic        flag_z, flag_n, flag_c, flag_v, flag_err;

  alu_pipe #(.DWIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_func  (alu_func),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_imm   (alu_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
    int          icyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one op (and out_ready) at a negedge until accepted; queue its expectation.
  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic [15:0] er, input logic [4:0] ef,
                       input logic ordy, input int lat, output int waits, output int icyc);
    exp_t e;
    waits = 0;
    icyc  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      alu_func  = f;
      alu_a     = a;
      alu_b     = b;
      alu_imm   = imm;
      out_ready = ordy;
      in_valid  = 1'b1;
      #1;
      if (in_ready) begin
        e.res  = er;
        e.fl   = ef;
        e.lat  = lat;
        e.icyc = cyc;
        icyc   = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      waits++;
    end
    total++;
    bad++;
    $display("FAIL issue_timeout: op %0d not accepted, got in_ready=0 expected 1", f);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare every transferred result against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h expected no result", alu_out);
        end else begin
          e = sb.pop_front();
          chk("result", alu_out, e.res);
          chk("flags", {flag_err, flag_v, flag_c, flag_n, flag_z}, e.fl);
          if (e.lat > 0) chk("latency", cyc - e.icyc, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int w, ic, seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_flags", {flag_err, flag_v, flag_c, flag_n, flag_z}, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Back-to-back, one per cycle
    issue(ALU_ADD, 16'h7FFF, 16'h0001, 16'h0, 16'h8000, 5'b01010, 1'b1, 1, w, ic);
    issue(ALU_SUB, 16'h0003, 16'h0005, 16'h0, 16'hFFFE, 5'b00010, 1'b1, 1, w, ic);
    chk("b2b_sub_waits", w, 0);
    issue(ALU_XOR, 16'hF0F0, 16'hFFFF, 16'h0, 16'h0F0F, 5'b00000, 1'b1, 1, w, ic);
    chk("b2b_xor_waits", w, 0);

    // Backpressure
    drain();
    issue(ALU_ADD, 16'h0002, 16'h0002, 16'h0, 16'h0004, 5'b00000, 1'b0, -1, w, ic);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_func = ALU_AND;
      alu_a    = 16'h00FF;
      alu_b    = 16'h0F0F;
      in_valid = 1'b1;
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_alu_out", alu_out, 16'h0004);
    end
    issue(ALU_AND, 16'h00FF, 16'h0F0F, 16'h0, 16'h000F, 5'b00000, 1'b1, 1, w, ic);
    chk("bp_release_waits", w, 0);

    // Shifts, compares, remaining arithmetic/logic corners
    issue(ALU_SRA,  16'h8000, 16'h0004, 16'h0,    16'hF800, 5'b00010, 1'b1, 1, w, ic);
    issue(ALU_SRL,  16'h8000, 16'h0004, 16'h0,    16'h0800, 5'b00000, 1'b1, 1, w, ic);
    issue(ALU_SLT,  16'hFFFF, 16'h0001, 16'h0,    16'h0001, 5'b00000, 1'b1, 1, w, ic);
    issue(ALU_SLTU, 16'hFFFF, 16'h0001, 16'h0,    16'h0000, 5'b00001, 1'b1, 1, w, ic);
    issue(ALU_SUB,  16'h0005, 16'h0005, 16'h0,    16'h0000, 5'b00101, 1'b1, 1, w, ic);
    issue(ALU_ADD,  16'hFFFF, 16'h0001, 16'h0,    16'h0000, 5'b00101, 1'b1, 1, w, ic);
    issue(ALU_ADDI, 16'h1234, 16'hFFFF, 16'h0001, 16'h1235, 5'b00000, 1'b1, 1, w, ic);
    issue(ALU_ANDI, 16'hABCD, 16'hFFFF, 16'h00F0, 16'h00C0, 5'b00000, 1'b1, 1, w, ic);
    issue(ALU_OR,   16'h1200, 16'h0034, 16'h0,    16'h1234, 5'b00000, 1'b1, 1, w, ic);
    issue(ALU_SLL,  16'h0001, 16'h0013, 16'h0,    16'h0008, 5'b00000, 1'b1, 1, w, ic);
    issue(ALU_SUB,  16'h8000, 16'h0001, 16'h0,    16'h7FFF, 5'b01100, 1'b1, 1, w, ic);
    issue(4'd14,    16'h1234, 16'h5678, 16'h0,    16'h0000, 5'b10001, 1'b1, 1, w, ic);

    // Multiply, unblocked, followed by an op that must wait for it
    issue(ALU_MUL,  16'hFFFF, 16'hFFFF, 16'h0,    16'h0001, 5'b00000, 1'b1, 17, w, ic);
    issue(ALU_XOR,  16'h00FF, 16'h00FF, 16'h0,    16'h0000, 5'b00001, 1'b1, 1, w, ic);
    chk("mul_stall_waits", w, 16);

    // Multiply completing into a blocked consumer
    drain();
    issue(ALU_MUL, 16'd300, 16'd300, 16'h0, 16'h5F90, 5'b00000, 1'b0, -1, w, ic);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1;
      else chk("mul_busy_in_ready", in_ready, 0);
    end
    if (seen == 0) begin
      total++;
      bad++;
      $display("FAIL mul_timeout: got out_valid=0 expected 1");
    end else begin
      chk("mul_latency", cyc - ic, 17);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("mul_hold_in_ready", in_ready, 0);
      chk("mul_hold_alu_out", alu_out, 16'h5F90);
    end
    @(negedge clk);
    out_ready = 1'b1;

    // Reset with a result pending
    drain();
    issue(ALU_ADD, 16'h0001, 16'h0001, 16'h0, 16'h0002, 5'b00000, 1'b0, -1, w, ic);
    @(negedge clk);
    #1 chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_alu_out", alu_out, 0);
    chk("mid_rst_flags", {flag_err, flag_v, flag_c, flag_n, flag_z}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Reset during a multiply discards it
    issue(ALU_MUL, 16'h0003, 16'h0003, 16'h0, 16'h0009, 5'b00000, 1'b1, 17, w, ic);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1 chk("mulrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mulrst_in_ready", in_ready, 1);
    issue(ALU_ADD, 16'h0001, 16'h0002, 16'h0, 16'h0003, 5'b00000, 1'b1, 1, w, ic);
    chk("mulrst_add_waits", w, 0);

    drain();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
